// File: rtl/rggen_axi4lite_request_fifo_if.sv
// ---------------------------------------------------------------------------
// rggen_axi4lite_if
//
// AXI4-Lite bundle shared by the request FIFO and its neighbours.
//
// Parameters
//   ID_WIDTH      : width of awid/arid/bid/rid. Zero means the bus has no IDs;
//                   the fields are still declared one bit wide so the bundle
//                   stays legal, but nothing gives them any meaning.
//   ADDRESS_WIDTH : width of awaddr/araddr.
//   BUS_WIDTH     : width of wdata/rdata. wstrb is BUS_WIDTH/8 bits wide.
//
// Modports
//   master : drives AW/W/AR requests and bready/rready. It receives the
//            request readies and the B/R responses.
//   slave  : the mirror image of master.
// ---------------------------------------------------------------------------
interface rggen_axi4lite_if #(
  parameter int ID_WIDTH      = 0,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  localparam int ID_W   = (ID_WIDTH > 0) ? ID_WIDTH : 1;
  localparam int STRB_W = BUS_WIDTH / 8;

  // Write address channel
  logic                     awvalid;
  logic                     awready;
  logic [ID_W-1:0]          awid;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0]               awprot;
  // Write data channel
  logic                     wvalid;
  logic                     wready;
  logic [BUS_WIDTH-1:0]     wdata;
  logic [STRB_W-1:0]        wstrb;
  // Write response channel
  logic                     bvalid;
  logic                     bready;
  logic [ID_W-1:0]          bid;
  logic [1:0]               bresp;
  // Read address channel
  logic                     arvalid;
  logic                     arready;
  logic [ID_W-1:0]          arid;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [2:0]               arprot;
  // Read data channel
  logic                     rvalid;
  logic                     rready;
  logic [ID_W-1:0]          rid;
  logic [1:0]               rresp;
  logic [BUS_WIDTH-1:0]     rdata;

  modport master (
    output awvalid, input awready, output awid, output awaddr, output awprot,
    output wvalid,  input wready,  output wdata, output wstrb,
    input  bvalid,  output bready, input bid,    input bresp,
    output arvalid, input arready, output arid,  output araddr, output arprot,
    input  rvalid,  output rready, input rid,    input rresp,   input rdata
  );

  modport slave (
    input  awvalid, output awready, input awid,  input awaddr, input awprot,
    input  wvalid,  output wready,  input wdata, input wstrb,
    output bvalid,  input bready,   output bid,  output bresp,
    input  arvalid, output arready, input arid,  input araddr, input arprot,
    output rvalid,  input rready,   output rid,  output rresp, output rdata
  );
endinterface

// File: rtl/rggen_axi4lite_request_fifo.sv
// ---------------------------------------------------------------------------
// rggen_axi4lite_request_fifo
//
// Request queue that sits in front of the AXI4-Lite register adapter. The AW,
// W and AR channels each get their own FIFO, so the three request streams
// are decoupled from one another. The readies returned to the external master
// come straight from flops, which means adapter back-pressure never reaches
// the interconnect through combinational logic. B and R go straight through.
//
// Parameters
//   ID_WIDTH      : ID width; 0 = no IDs. Without IDs nothing is stored and
//                   the ID outputs are tied low.
//   ADDRESS_WIDTH : address width.
//   BUS_WIDTH     : data width.
//   DEPTH         : entries per request FIFO (power of two, 2..16).
//
// Ports
//   i_clk     : clock, rising edge.
//   i_rst     : asynchronous active-high reset. It empties every FIFO and
//               drops the valids on master_if at once.
//   slave_if  : faces the external AXI4-Lite master.
//   master_if : faces the register adapter.
// ---------------------------------------------------------------------------

// One request FIFO channel. Its pointers are one bit wider than the index,
// which tells full apart from empty. The ready toward the producer is held
// in a flop and loaded with !full of the next state.
module rggen_axi4lite_request_fifo_chan #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);
  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "rggen_axi4lite_request_fifo: DEPTH must be a power of two in 2..16");
  end

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop, empty, full;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[IW-1:0] == rptr_q[IW-1:0]) && (wptr_q[IW] != rptr_q[IW]);
    push    = i_valid && ready_q;
    pop     = !empty && i_ready;
    wptr_d  = wptr_q + PW'(push);
    rptr_d  = rptr_q + PW'(pop);
    // Ready is loaded from the next-state pointers. It therefore falls on the
    // edge that fills the FIFO and rises on the edge that pops from full.
    ready_d = !((wptr_d[IW-1:0] == rptr_d[IW-1:0]) && (wptr_d[IW] != rptr_d[IW]));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ready_q <= ready_d;
    end
  end

  // The payload array has no reset. Entries past the read pointer are never
  // presented, because valid is taken from the pointers alone.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wptr_q[IW-1:0]] <= i_data;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = !empty;
  assign o_data  = mem_q[rptr_q[IW-1:0]];

  a_no_push_when_full : assert property (
    @(posedge i_clk) disable iff (i_rst) push |-> !full
  );
  a_stable_under_stall : assert property (
    @(posedge i_clk) disable iff (i_rst) (o_valid && !i_ready) |=> $stable(o_data)
  );
endmodule

module rggen_axi4lite_request_fifo #(
  parameter int ID_WIDTH      = 0,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int DEPTH         = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  rggen_axi4lite_if.slave  slave_if,
  rggen_axi4lite_if.master master_if
);
  localparam int STRB_W   = BUS_WIDTH / 8;
  localparam int ID_STORE = (ID_WIDTH > 0) ? ID_WIDTH : 0;
  // Address-channel entry layout: {id (if any), addr, prot}
  localparam int AX_W     = ID_STORE + ADDRESS_WIDTH + 3;
  // Write-data entry layout: {data, strb}
  localparam int W_W      = BUS_WIDTH + STRB_W;

  logic [AX_W-1:0] aw_in, aw_out;
  logic [AX_W-1:0] ar_in, ar_out;
  logic [W_W-1:0]  w_in,  w_out;

  if (ID_WIDTH > 0) begin : g_id
    assign aw_in          = {slave_if.awid, slave_if.awaddr, slave_if.awprot};
    assign ar_in          = {slave_if.arid, slave_if.araddr, slave_if.arprot};
    assign master_if.awid = aw_out[AX_W-1 -: ID_WIDTH];
    assign master_if.arid = ar_out[AX_W-1 -: ID_WIDTH];
    assign slave_if.bid   = master_if.bid;
    assign slave_if.rid   = master_if.rid;
  end else begin : g_no_id
    // Without IDs, the one-bit ID fields are neither queued nor forwarded.
    logic unused_ids;
    assign unused_ids     = ^{slave_if.awid, slave_if.arid, master_if.bid, master_if.rid};
    assign aw_in          = {slave_if.awaddr, slave_if.awprot};
    assign ar_in          = {slave_if.araddr, slave_if.arprot};
    assign master_if.awid = '0;
    assign master_if.arid = '0;
    assign slave_if.bid   = '0;
    assign slave_if.rid   = '0;
  end

  assign w_in = {slave_if.wdata, slave_if.wstrb};

  rggen_axi4lite_request_fifo_chan #(.WIDTH(AX_W), .DEPTH(DEPTH)) u_aw_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (slave_if.awvalid),
    .o_ready (slave_if.awready),
    .i_data  (aw_in),
    .o_valid (master_if.awvalid),
    .i_ready (master_if.awready),
    .o_data  (aw_out)
  );

  rggen_axi4lite_request_fifo_chan #(.WIDTH(W_W), .DEPTH(DEPTH)) u_w_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (slave_if.wvalid),
    .o_ready (slave_if.wready),
    .i_data  (w_in),
    .o_valid (master_if.wvalid),
    .i_ready (master_if.wready),
    .o_data  (w_out)
  );

  rggen_axi4lite_request_fifo_chan #(.WIDTH(AX_W), .DEPTH(DEPTH)) u_ar_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (slave_if.arvalid),
    .o_ready (slave_if.arready),
    .i_data  (ar_in),
    .o_valid (master_if.arvalid),
    .i_ready (master_if.arready),
    .o_data  (ar_out)
  );

  assign master_if.awaddr = aw_out[3 +: ADDRESS_WIDTH];
  assign master_if.awprot = aw_out[2:0];
  assign master_if.araddr = ar_out[3 +: ADDRESS_WIDTH];
  assign master_if.arprot = ar_out[2:0];
  assign master_if.wdata  = w_out[STRB_W +: BUS_WIDTH];
  assign master_if.wstrb  = w_out[STRB_W-1:0];

  // Response channels are wired straight through, with no storage.
  assign slave_if.bvalid  = master_if.bvalid;
  assign slave_if.bresp   = master_if.bresp;
  assign slave_if.rvalid  = master_if.rvalid;
  assign slave_if.rresp   = master_if.rresp;
  assign slave_if.rdata   = master_if.rdata;
  assign master_if.bready = slave_if.bready;
  assign master_if.rready = slave_if.rready;
endmodule

// File: tb/tb_rggen_axi4lite_request_fifo.sv
module tb_rggen_axi4lite_request_fifo;
  localparam int DA = 4;   // depth of instance A (ID_WIDTH=4)
  localparam int DB = 2;   // depth of instance B (no ID)

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rggen_axi4lite_if #(.ID_WIDTH(4), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) sa ();
  rggen_axi4lite_if #(.ID_WIDTH(4), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) ma ();
  rggen_axi4lite_if #(.ID_WIDTH(0), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) sb ();
  rggen_axi4lite_if #(.ID_WIDTH(0), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) mb ();

  rggen_axi4lite_request_fifo #(
    .ID_WIDTH(4), .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .DEPTH(DA)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .slave_if(sa), .master_if(ma)
  );

  rggen_axi4lite_request_fifo #(
    .ID_WIDTH(0), .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .DEPTH(DB)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .slave_if(sb), .master_if(mb)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cycle   = 0;

  // Reference model: each channel is a plain queue of entries, capped at its depth.
  logic [63:0] awq[$], wq[$], arq[$], arqb[$];
  logic [63:0] arpop_a[$], arpop_b[$];
  bit acc_aw, acc_w, acc_ar, acc_arb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    awq.delete(); wq.delete(); arq.delete(); arqb.delete();
    acc_aw = 0; acc_w = 0; acc_ar = 0; acc_arb = 0;
  endtask

  // Applies one clock edge to the model, using the inputs as they stood before the edge.
  task automatic model_edge();
    bit paw, pw, par, parb;
    if (rst) begin
      model_clear();
      return;
    end
    acc_aw  = sa.awvalid && (awq.size() < DA);
    acc_w   = sa.wvalid  && (wq.size()  < DA);
    acc_ar  = sa.arvalid && (arq.size() < DA);
    acc_arb = sb.arvalid && (arqb.size() < DB);
    paw  = (awq.size()  > 0) && ma.awready;
    pw   = (wq.size()   > 0) && ma.wready;
    par  = (arq.size()  > 0) && ma.arready;
    parb = (arqb.size() > 0) && mb.arready;
    if (paw)  void'(awq.pop_front());
    if (pw)   void'(wq.pop_front());
    if (par)  arpop_a.push_back(arq.pop_front());
    if (parb) arpop_b.push_back(arqb.pop_front());
    if (acc_aw)  awq.push_back(64'({sa.awid, sa.awaddr, sa.awprot}));
    if (acc_w)   wq.push_back(64'({sa.wdata, sa.wstrb}));
    if (acc_ar)  arq.push_back(64'({sa.arid, sa.araddr, sa.arprot}));
    if (acc_arb) arqb.push_back(64'({sb.araddr, sb.arprot}));
  endtask

  task automatic check_state();
    chk("awready", sa.awready, awq.size() < DA);
    chk("awvalid", ma.awvalid, awq.size() > 0);
    if (awq.size() > 0) chk("aw_payload", {ma.awid, ma.awaddr, ma.awprot}, awq[0]);
    chk("wready", sa.wready, wq.size() < DA);
    chk("wvalid", ma.wvalid, wq.size() > 0);
    if (wq.size() > 0) chk("w_payload", {ma.wdata, ma.wstrb}, wq[0]);
    chk("arready", sa.arready, arq.size() < DA);
    chk("arvalid", ma.arvalid, arq.size() > 0);
    if (arq.size() > 0) chk("ar_payload", {ma.arid, ma.araddr, ma.arprot}, arq[0]);
    chk("b_arready", sb.arready, arqb.size() < DB);
    chk("b_arvalid", mb.arvalid, arqb.size() > 0);
    if (arqb.size() > 0) chk("b_ar_payload", {mb.araddr, mb.arprot}, arqb[0]);
    chk("bvalid_pt", sa.bvalid, ma.bvalid);
    chk("bid_pt",    sa.bid,    ma.bid);
    chk("bresp_pt",  sa.bresp,  ma.bresp);
    chk("rvalid_pt", sa.rvalid, ma.rvalid);
    chk("rid_pt",    sa.rid,    ma.rid);
    chk("rresp_pt",  sa.rresp,  ma.rresp);
    chk("rdata_pt",  sa.rdata,  ma.rdata);
    chk("bready_pt", ma.bready, sa.bready);
    chk("rready_pt", ma.rready, sa.rready);
    chk("b_rdata_pt", sb.rdata, mb.rdata);
  endtask

  task automatic cyc();
    ma.bvalid = 1'($urandom); ma.bid = 4'($urandom); ma.bresp = 2'($urandom);
    ma.rvalid = 1'($urandom); ma.rid = 4'($urandom); ma.rresp = 2'($urandom);
    ma.rdata  = $urandom;     sa.bready = 1'($urandom); sa.rready = 1'($urandom);
    mb.rdata  = $urandom;
    @(posedge clk);
    model_edge();
    cycle++;
    #1;
    check_state();
  endtask

  initial begin
    logic [63:0] e;
    int first_pop;
    // idle every driven signal
    sa.awvalid = 0; sa.awid = 0; sa.awaddr = 0; sa.awprot = 0;
    sa.wvalid = 0; sa.wdata = 0; sa.wstrb = 0; sa.bready = 0;
    sa.arvalid = 0; sa.arid = 0; sa.araddr = 0; sa.arprot = 0; sa.rready = 0;
    ma.awready = 0; ma.wready = 0; ma.bvalid = 0; ma.bid = 0; ma.bresp = 0;
    ma.arready = 0; ma.rvalid = 0; ma.rid = 0; ma.rresp = 0; ma.rdata = 0;
    sb.awvalid = 0; sb.awid = 0; sb.awaddr = 0; sb.awprot = 0;
    sb.wvalid = 0; sb.wdata = 0; sb.wstrb = 0; sb.bready = 0;
    sb.arvalid = 0; sb.arid = 0; sb.araddr = 0; sb.arprot = 0; sb.rready = 0;
    mb.awready = 0; mb.wready = 0; mb.bvalid = 0; mb.bid = 0; mb.bresp = 0;
    mb.arready = 0; mb.rvalid = 0; mb.rid = 0; mb.rresp = 0; mb.rdata = 0;
    model_clear();

    // Reset, then release
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    #1;
    chk("rst_awready", sa.awready, 1);
    chk("rst_wready",  sa.wready,  1);
    chk("rst_arready", sa.arready, 1);
    chk("rst_awvalid", ma.awvalid, 0);
    chk("rst_b_arready", sb.arready, 1);
    cyc();

    // Single write with the adapter ready
    ma.awready = 1; ma.wready = 1;
    sa.awvalid = 1; sa.awid = 4'h0; sa.awaddr = 8'h10; sa.awprot = 3'd0;
    sa.wvalid = 1;  sa.wdata = 32'hDEADBEEF; sa.wstrb = 4'hF;
    cyc();
    sa.awvalid = 0; sa.wvalid = 0;
    chk("wr_awvalid", ma.awvalid, 1);
    chk("wr_awaddr",  ma.awaddr,  8'h10);
    chk("wr_wvalid",  ma.wvalid,  1);
    chk("wr_wdata",   ma.wdata,   32'hDEADBEEF);
    chk("wr_wstrb",   ma.wstrb,   4'hF);
    ma.bvalid = 1; ma.bresp = 2'b00;
    #1;
    chk("wr_bvalid", sa.bvalid, 1);
    chk("wr_bresp",  sa.bresp,  2'b00);
    cyc();
    chk("wr_drained", ma.awvalid, 0);

    // Five reads against a stalled adapter, depth 4
    ma.arready = 0; arpop_a.delete();
    sa.arvalid = 1; sa.arid = 0; sa.arprot = 0;
    for (int i = 0; i < 4; i++) begin
      sa.araddr = 8'(4 * i);
      cyc();
      chk("fill_acc", acc_ar, 1);
    end
    chk("full_arready", sa.arready, 0);
    sa.araddr = 8'h10;
    cyc();
    chk("full_block", acc_ar, 0);
    ma.arready = 1;
    cyc();
    first_pop = cycle;
    chk("ready_after_pop", sa.arready, 1);
    cyc();
    chk("fifth_acc", acc_ar, 1);
    chk("fifth_acc_cycle", cycle - first_pop, 1);
    sa.arvalid = 0;
    repeat (6) cyc();
    chk("rd_pop_count", arpop_a.size(), 5);
    for (int i = 0; i < 5 && i < arpop_a.size(); i++) begin
      e = arpop_a[i];
      chk("rd_order", e[10:3], 8'(4 * i));
    end

    // W arrives three cycles ahead of its AW
    ma.awready = 0; ma.wready = 0;
    sa.wvalid = 1; sa.wdata = 32'h12345678; sa.wstrb = 4'hF;
    cyc();
    chk("w_early_acc", acc_w, 1);
    sa.wvalid = 0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("aw_absent", ma.awvalid, 0);
      chk("w_waiting", ma.wvalid, 1);
    end
    sa.awvalid = 1; sa.awaddr = 8'h20; sa.awid = 0; sa.awprot = 0;
    cyc();
    sa.awvalid = 0;
    chk("pair_awvalid", ma.awvalid, 1);
    chk("pair_wvalid",  ma.wvalid,  1);
    chk("pair_awaddr",  ma.awaddr,  8'h20);
    chk("pair_wdata",   ma.wdata,   32'h12345678);
    ma.awready = 1; ma.wready = 1;
    cyc();
    chk("pair_done_aw", ma.awvalid, 0);
    chk("pair_done_w",  ma.wvalid,  0);

    // Back-to-back reads on the depth-2 instance
    mb.arready = 1; arpop_b.delete();
    sb.arvalid = 1; sb.arprot = 0;
    for (int i = 0; i < 100; i++) begin
      sb.araddr = 8'(i);
      cyc();
      chk("b2b_acc", acc_arb, 1);
    end
    sb.arvalid = 0;
    repeat (3) cyc();
    chk("b2b_count", arpop_b.size(), 100);
    for (int i = 0; i < 100 && i < arpop_b.size(); i++) begin
      e = arpop_b[i];
      chk("b2b_order", e[10:3], 8'(i));
    end

    // Asynchronous reset with two AW entries queued
    ma.awready = 0;
    sa.awvalid = 1;
    for (int i = 0; i < 2; i++) begin
      sa.awaddr = 8'(8'h80 + i); sa.awid = 4'(i + 1);
      cyc();
    end
    sa.awvalid = 0;
    chk("pre_rst_awvalid", ma.awvalid, 1);
    #3 rst = 1;
    #1;
    chk("async_awvalid", ma.awvalid, 0);
    model_clear();
    check_state();
    @(posedge clk);
    @(negedge clk) rst = 0;
    cyc();
    chk("post_rst_awready", sa.awready, 1);
    chk("post_rst_arvalid", ma.arvalid, 0);

    // Reads with interleaved IDs
    ma.arready = 1; arpop_a.delete();
    sa.arvalid = 1; sa.arid = 4'd3; sa.araddr = 8'h40; sa.arprot = 0;
    cyc();
    sa.arid = 4'd9; sa.araddr = 8'h44;
    cyc();
    sa.arvalid = 0;
    repeat (3) cyc();
    chk("id_count", arpop_a.size(), 2);
    if (arpop_a.size() == 2) begin
      e = arpop_a[0]; chk("id_first",  e[14:11], 4'd3);
      e = arpop_a[1]; chk("id_second", e[14:11], 4'd9);
    end

    // Random traffic on every request channel
    for (int n = 0; n < 400; n++) begin
      sa.awvalid = ($urandom_range(0, 9) < 6); sa.awid = 4'($urandom);
      sa.awaddr = 8'($urandom); sa.awprot = 3'($urandom);
      sa.wvalid = ($urandom_range(0, 9) < 6); sa.wdata = $urandom; sa.wstrb = 4'($urandom);
      sa.arvalid = ($urandom_range(0, 9) < 6); sa.arid = 4'($urandom);
      sa.araddr = 8'($urandom); sa.arprot = 3'($urandom);
      ma.awready = 1'($urandom); ma.wready = 1'($urandom); ma.arready = 1'($urandom);
      sb.arvalid = 1'($urandom); sb.araddr = 8'($urandom); sb.arprot = 3'($urandom);
      mb.arready = 1'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
